// File: rtl/arb8way16_if.sv
// arb8way16_if: producer/consumer bundle around the 8-way round-robin arbiter.
//   in_valid[8], in_data[128] : per-source requests and packed 16-bit words
//   in_ready[8]               : per-source accept (one-hot or zero)
//   sel[3]                    : current combinational winner index
//   out_valid/out_data/out_src: registered output stage toward the consumer
//   out_ready                 : consumer accept
// modport slave is the arbiter side; modport master is the producer/consumer side.
interface arb8way16_if;
    logic [7:0]   in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_ready;
    logic [2:0]   sel;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_src;
    logic         out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output sel,
        output out_valid,
        output out_data,
        output out_src
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  sel,
        input  out_valid,
        input  out_data,
        input  out_src
    );
endinterface

// File: rtl/arb8way16.sv
// arb8way16: round-robin arbiter sharing one 16-bit datapath between 8 sources,
// with optional burst locking (BURST consecutive beats per grant, 1..15).
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : arb8way16_if.slave (requests, word selector code, output stage)
// in_ready and sel are combinational from the registered state and in_valid;
// out_valid/out_data/out_src come from a pass-through output register.
module arb8way16 #(
    parameter int unsigned BURST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    arb8way16_if.slave   bus
);
    localparam int unsigned N  = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic {
        ST_FREE,
        ST_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   lidx_q, lidx_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   src_q, src_d;

    logic            can_accept_c;
    logic            lock_hit_c;
    logic            release_c;
    logic            rr_found_c;
    logic [IW-1:0]   rr_idx_c;
    logic            win_valid_c;
    logic [IW-1:0]   win_idx_c;
    logic            xfer_c;
    logic [CW:0]     beats_c;
    logic [DW-1:0]   win_data_c;

    // Output register may reload in the same cycle its word is consumed.
    assign can_accept_c = !valid_q || bus.out_ready;

    assign lock_hit_c = (state_q == ST_LOCK) && bus.in_valid[lidx_q];
    assign release_c  = (state_q == ST_LOCK) && can_accept_c && !bus.in_valid[lidx_q];

    // Rotating priority scan: first requester at ptr, ptr+1, ... (mod 8).
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!rr_found_c && bus.in_valid[ptr_q + IW'(k)]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = ptr_q + IW'(k);
            end
        end
    end

    // A held lock overrides rotation; otherwise the scan winner from the old ptr
    // is used, so a lock release costs no idle cycle.
    assign win_valid_c = lock_hit_c || rr_found_c;
    assign win_idx_c   = lock_hit_c ? lidx_q : rr_idx_c;
    assign xfer_c      = win_valid_c && can_accept_c;
    assign win_data_c  = bus.in_data[{win_idx_c, 4'h0} +: DW];

    // Beat count of the grant this transfer belongs to; a fresh grant starts at 1.
    assign beats_c = (lock_hit_c ? {1'b0, bcnt_q} : (CW+1)'(0)) + (CW+1)'(1);

    assign bus.sel       = win_valid_c ? win_idx_c : IW'(0);
    assign bus.in_ready  = xfer_c ? (N'(1) << win_idx_c) : N'(0);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FREE;
            ptr_q   <= '0;
            lidx_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lidx_q  <= lidx_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    // Next-state: drain, lock release, then transfer (transfer wins any overlap).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lidx_d  = lidx_q;
        bcnt_d  = bcnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;

        if (valid_q && bus.out_ready && !xfer_c) begin
            valid_d = 1'b0;
        end

        if (release_c) begin
            state_d = ST_FREE;
            bcnt_d  = '0;
            ptr_d   = lidx_q + IW'(1);
        end

        if (xfer_c) begin
            valid_d = 1'b1;
            data_d  = win_data_c;
            src_d   = win_idx_c;
            if (beats_c < (CW+1)'(BURST)) begin
                state_d = ST_LOCK;
                lidx_d  = win_idx_c;
                bcnt_d  = beats_c[CW-1:0];
            end else begin
                state_d = ST_FREE;
                bcnt_d  = '0;
                ptr_d   = win_idx_c + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_arb8way16.sv
// Bench for arb8way16: directed scenarios plus randomized traffic checked
// against a behavioural model, on a BURST=1 instance (a) and a BURST=4 instance (b).
module tb_arb8way16;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arb8way16_if bus_a ();
    arb8way16_if bus_b ();

    arb8way16 #(.BURST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    arb8way16 #(.BURST(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state, index 0 = instance a, 1 = instance b.
    int          m_ptr  [2];
    int          m_lidx [2];
    int          m_bcnt [2];
    bit          m_lock [2];
    bit          m_ov   [2];
    logic [15:0] m_od   [2];
    int          m_os   [2];

    function automatic int m_burst(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic m_init();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_lidx[d] = 0; m_bcnt[d] = 0; m_lock[d] = 0;
            m_ov[d] = 0; m_od[d] = 16'h0000; m_os[d] = 0;
        end
    endtask

    // Winner index, or -1 when nobody requests.
    function automatic int m_win(int d, logic [7:0] v);
        if (m_lock[d] && v[m_lidx[d]]) return m_lidx[d];
        for (int k = 0; k < 8; k++)
            if (v[(m_ptr[d] + k) % 8]) return (m_ptr[d] + k) % 8;
        return -1;
    endfunction

    task automatic m_advance(int d, logic [7:0] v, logic [127:0] data, logic ordy);
        int w;
        bit can;
        bit xfer;
        int beats;
        w     = m_win(d, v);
        can   = !m_ov[d] || ordy;
        xfer  = (w >= 0) && can;
        beats = (m_lock[d] && v[m_lidx[d]]) ? m_bcnt[d] + 1 : 1;
        if (m_ov[d] && ordy && !xfer) m_ov[d] = 0;
        if (m_lock[d] && can && !v[m_lidx[d]]) begin
            m_lock[d] = 0; m_bcnt[d] = 0; m_ptr[d] = (m_lidx[d] + 1) % 8;
        end
        if (xfer) begin
            m_od[d] = data[16*w +: 16];
            m_os[d] = w;
            m_ov[d] = 1;
            if (beats < m_burst(d)) begin
                m_lock[d] = 1; m_lidx[d] = w; m_bcnt[d] = beats;
            end else begin
                m_lock[d] = 0; m_bcnt[d] = 0; m_ptr[d] = (w + 1) % 8;
            end
        end
    endtask

    task automatic idle_inputs();
        bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_init();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got a=%b b=%b expected 0", bus_a.out_valid, bus_b.out_valid);
        end
        n_checks++;
        if (bus_a.out_data !== 16'h0000 || bus_b.out_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out_data: got a=%h b=%h expected 0000", bus_a.out_data, bus_b.out_data);
        end
        n_checks++;
        if (bus_a.out_src !== 3'd0) begin
            n_fail++; $display("FAIL reset_out_src: got %0d expected 0", bus_a.out_src);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_a.sel !== 3'd0 || bus_a.in_ready !== 8'h00) begin
            n_fail++; $display("FAIL idle_sel_ready: got sel=%0d rdy=%h expected 0/00", bus_a.sel, bus_a.in_ready);
        end
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'h0000) begin
            n_fail++; $display("FAIL idle_out: got v=%b d=%h expected 0/0000", bus_a.out_valid, bus_a.out_data);
        end
    endtask

    task automatic test_full_rr();
        logic [127:0] d;
        int e;
        reset_all();
        for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'h1000 + 16'(i);
        bus_a.in_data = d; bus_a.in_valid = 8'hFF; bus_a.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            e = k % 8;
            @(negedge clk);
            n_checks++;
            if (bus_a.sel !== 3'(e) || bus_a.in_ready !== (8'h01 << e)) begin
                n_fail++; $display("FAIL rr_grant%0d: got sel=%0d rdy=%h expected %0d", k, bus_a.sel, bus_a.in_ready, e);
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h1000 + 16'(e) || bus_a.out_src !== 3'(e)) begin
                n_fail++; $display("FAIL rr_word%0d: got v=%b d=%h s=%0d expected %h/%0d", k, bus_a.out_valid, bus_a.out_data, bus_a.out_src, 16'h1000 + 16'(e), e);
            end
        end
        bus_a.in_valid = 8'h00;
    endtask

    task automatic test_sparse_wrap();
        reset_all();
        bus_a.in_data = {8{16'h5A00}}; bus_a.in_data[16*2 +: 16] = 16'h5A02;
        bus_a.in_valid = 8'b0010_0000; bus_a.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.sel !== 3'd5) begin
            n_fail++; $display("FAIL wrap_pre: got sel=%0d expected 5", bus_a.sel);
        end
        @(posedge clk); #1;
        bus_a.in_valid = 8'b0000_0101;
        @(negedge clk);
        n_checks++;
        if (bus_a.sel !== 3'd0 || bus_a.in_ready !== 8'h01) begin
            n_fail++; $display("FAIL wrap_first: got sel=%0d rdy=%h expected 0/01", bus_a.sel, bus_a.in_ready);
        end
        @(posedge clk); #1;
        bus_a.in_valid = 8'b0000_0100;
        @(negedge clk);
        n_checks++;
        if (bus_a.sel !== 3'd2 || bus_a.out_src !== 3'd0) begin
            n_fail++; $display("FAIL wrap_second: got sel=%0d src=%0d expected 2/0", bus_a.sel, bus_a.out_src);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_a.out_src !== 3'd2 || bus_a.out_data !== 16'h5A02) begin
            n_fail++; $display("FAIL wrap_word: got src=%0d d=%h expected 2/5a02", bus_a.out_src, bus_a.out_data);
        end
        bus_a.in_valid = 8'h00;
    endtask

    task automatic test_backpressure();
        reset_all();
        for (int i = 0; i < 8; i++) bus_a.in_data[16*i +: 16] = 16'h2000 + 16'(i);
        bus_a.in_data[16*4 +: 16] = 16'hBEEF;
        bus_a.in_valid = 8'h10; bus_a.out_ready = 1'b0;
        @(posedge clk); #1;
        bus_a.in_valid = 8'h0F;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL bp_load: got v=%b d=%h expected 1/beef", bus_a.out_valid, bus_a.out_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.in_ready !== 8'h00 || bus_a.out_data !== 16'hBEEF || bus_a.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_stall%0d: got rdy=%h v=%b d=%h expected 00/1/beef", k, bus_a.in_ready, bus_a.out_valid, bus_a.out_data);
            end
        end
        bus_a.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus_a.in_ready !== 8'h01) begin
            n_fail++; $display("FAIL bp_release_ready: got %h expected 01", bus_a.in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h2000 || bus_a.out_src !== 3'd0) begin
            n_fail++; $display("FAIL bp_next_word: got v=%b d=%h s=%0d expected 1/2000/0", bus_a.out_valid, bus_a.out_data, bus_a.out_src);
        end
        bus_a.in_valid = 8'h00;
    endtask

    task automatic test_burst();
        int exp_seq [10] = '{3, 3, 3, 3, 5, 5, 5, 5, 3, 3};
        reset_all();
        for (int i = 0; i < 8; i++) bus_b.in_data[16*i +: 16] = 16'h3000 + 16'(i);
        bus_b.in_valid = 8'b0010_1000; bus_b.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus_b.sel !== 3'(exp_seq[k])) begin
                n_fail++; $display("FAIL burst_sel%0d: got %0d expected %0d", k, bus_b.sel, exp_seq[k]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus_b.out_src !== 3'(exp_seq[k]) || bus_b.out_data !== 16'h3000 + 16'(exp_seq[k])) begin
                n_fail++; $display("FAIL burst_word%0d: got s=%0d d=%h expected %0d", k, bus_b.out_src, bus_b.out_data, exp_seq[k]);
            end
        end
        // Source 3 leaves mid-burst: source 5 must be granted on the very next edge.
        bus_b.in_valid = 8'b0010_0000;
        @(negedge clk);
        n_checks++;
        if (bus_b.sel !== 3'd5 || bus_b.in_ready !== 8'h20) begin
            n_fail++; $display("FAIL burst_release_sel: got sel=%0d rdy=%h expected 5/20", bus_b.sel, bus_b.in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_src !== 3'd5) begin
            n_fail++; $display("FAIL burst_release_word: got v=%b s=%0d expected 1/5", bus_b.out_valid, bus_b.out_src);
        end
        bus_b.in_valid = 8'h00;
    endtask

    task automatic test_async_reset();
        reset_all();
        bus_a.in_data = {8{16'h7777}}; bus_a.in_valid = 8'hFF; bus_a.out_ready = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (bus_a.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got v=%b expected 1", bus_a.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'h0000) begin
            n_fail++; $display("FAIL areset_drop: got v=%b d=%h expected 0/0000", bus_a.out_valid, bus_a.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus_a.sel !== 3'd0 || bus_a.in_ready !== 8'h01) begin
            n_fail++; $display("FAIL areset_ptr: got sel=%0d rdy=%h expected 0/01", bus_a.sel, bus_a.in_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0]   v;
        logic [127:0] dat;
        logic         ordy;
        int           w;
        bit           can;
        logic [7:0]   exp_rdy;
        logic [2:0]   exp_sel;
        logic [7:0]   got_rdy;
        logic [2:0]   got_sel;
        logic         got_ov;
        logic [15:0]  got_od;
        logic [2:0]   got_os;
        int           errs;
        for (int d = 0; d < 2; d++) begin
            reset_all();
            errs = 0;
            for (int c = 0; c < 400; c++) begin
                v    = 8'($urandom) & 8'($urandom);
                for (int i = 0; i < 8; i++) dat[16*i +: 16] = 16'($urandom);
                ordy = ($urandom_range(0, 3) != 0);
                if (d == 0) begin
                    bus_a.in_valid = v; bus_a.in_data = dat; bus_a.out_ready = ordy;
                end else begin
                    bus_b.in_valid = v; bus_b.in_data = dat; bus_b.out_ready = ordy;
                end
                @(negedge clk);
                w       = m_win(d, v);
                can     = !m_ov[d] || ordy;
                exp_sel = (w >= 0) ? 3'(w) : 3'd0;
                exp_rdy = (w >= 0 && can) ? (8'h01 << w) : 8'h00;
                if (d == 0) begin
                    got_rdy = bus_a.in_ready; got_sel = bus_a.sel;
                    got_ov = bus_a.out_valid; got_od = bus_a.out_data; got_os = bus_a.out_src;
                end else begin
                    got_rdy = bus_b.in_ready; got_sel = bus_b.sel;
                    got_ov = bus_b.out_valid; got_od = bus_b.out_data; got_os = bus_b.out_src;
                end
                n_checks++;
                if (got_sel !== exp_sel || got_rdy !== exp_rdy) begin
                    n_fail++;
                    if (errs++ < 5) $display("FAIL rand%0d_arb c=%0d: got sel=%0d rdy=%h expected %0d/%h", d, c, got_sel, got_rdy, exp_sel, exp_rdy);
                end
                n_checks++;
                if (got_ov !== m_ov[d] || got_od !== m_od[d] || got_os !== 3'(m_os[d])) begin
                    n_fail++;
                    if (errs++ < 5) $display("FAIL rand%0d_out c=%0d: got v=%b d=%h s=%0d expected %b/%h/%0d", d, c, got_ov, got_od, got_os, m_ov[d], m_od[d], m_os[d]);
                end
                @(posedge clk);
                m_advance(d, v, dat, ordy);
                #1;
            end
            idle_inputs();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_full_rr();
        test_sparse_wrap();
        test_backpressure();
        test_burst();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arb8way16.md
Name: arb8way16

Overview:
- Round-robin arbiter/scheduler that shares one 16-bit datapath between 8 requesters. It decides which source drives the 8-way 16-bit word selector.
- It exposes the winning index as the selector code and registers the selected word into a single valid/ready output stage.
- It sits between 8 producer ports and one consumer, such as a shared register/RAM write port.
- Optional burst locking lets a winner keep the datapath for several consecutive beats.

Parameters:
- BURST, 1, max consecutive transfers granted to one source before priority rotates (1..15).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  8  per-source request; bit i = source i has a word.
- in_data  in  128  packed source words; source i at [16*i+15:16*i].
- in_ready  out  8  per-source accept; at most one bit set (one-hot or zero).
- sel  out  3  index of the current combinational winner; drives the word selector; 0 when no request.
- out_valid  out  1  registered output word valid.
- out_data  out  16  registered selected word.
- out_src  out  3  source index of out_data.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (async assert, sync release) sets:
  - out_valid=0, out_data=16'h0000, out_src=0.
  - Priority pointer ptr=0, burst counter bcnt=0, lock flag lock=0, locked index lidx=0.
- can_accept = !out_valid | out_ready. This is a pass-through output register: a new word can load in the same cycle the old one is consumed.
- Winner selection (combinational):
  - If lock=1 and in_valid[lidx]=1, then winner=lidx.
  - Otherwise, the winner is the first set bit of in_valid scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - If no bit is set, there is no winner.
- sel = winner index (0 if none). in_ready[winner]=can_accept; all other in_ready bits are 0.
- Transfer occurs on the clock edge where in_valid[i] & in_ready[i] holds. On a transfer:
  - out_data<=in_data slot i; out_src<=i; out_valid<=1.
  - Burst handling, with bcnt counting completed beats of the current grant:
    - If bcnt+1 < BURST: lock<=1, lidx<=i, bcnt<=bcnt+1, ptr unchanged.
    - Else: lock<=0, bcnt<=0, ptr<=(i+1) mod 8.
- If out_valid & out_ready and there is no transfer, out_valid<=0. out_data and out_src hold their values.
- If out_valid & !out_ready (stall):
  - All in_ready=0.
  - out_data, out_src and out_valid hold stable.
  - lock, bcnt and ptr hold.
- Lock release: if lock=1, can_accept=1 and in_valid[lidx]=0, then:
  - lock<=0, bcnt<=0, ptr<=(lidx+1) mod 8.
  - The same cycle arbitrates normally among the other sources from the old ptr, so no bubble is inserted.
  - If a transfer from another source occurs in that cycle, the transfer update rules take precedence.
- BURST=1: lock never sets; this is pure round-robin.
- Latency: one cycle from the accept edge to out_valid. With out_ready held high, throughput is 1 word/cycle.
- Wrap-around: ptr 7 → 0. A winner at index 7 rotates ptr to 0.
- Fairness: with all 8 sources valid, out_ready=1 and BURST=1, grant order is 0,1,…,7,0.
- Reset asserted mid-operation drops out_valid and discards any in-flight word; no partial transfer survives.
- Sources must hold in_valid/in_data stable until accepted. The arbiter does not check this.

Test Plan:
- Reset then idle: after rst_n rises with in_valid=0 → out_valid=0, out_data=0, in_ready=0, sel=0.
- Full contention, BURST=1, out_ready=1:
  - Stimulus: in_valid=8'hFF, slot i data=16'h1000+i.
  - Expected: out_data sequence 1000,1001,…,1007,1000 on consecutive cycles; out_src 0..7,0.
- Sparse wrap:
  - Stimulus: ptr at 6 (after granting 5), in_valid=8'b0000_0101.
  - Expected: grant 0 first, then 2; sel=0 then 2.
- Backpressure:
  - Stimulus: out_valid=1 with out_data=16'hBEEF, out_ready=0 for 3 cycles, in_valid=8'h0F.
  - Expected: in_ready=0, out_data stays BEEF. On out_ready=1, the next word loads in the same cycle.
- Burst, BURST=4:
  - Stimulus: sources 3 and 5 always valid, ptr=3.
  - Expected: sources 3,3,3,3,5,5,5,5,3 in order.
  - Drop source 3's valid after 2 beats → lock releases and source 5 is granted with no idle cycle.
- Async reset mid-stall:
  - Stimulus: assert rst_n=0 while out_valid=1.
  - Expected: out_valid=0 immediately without waiting for a clock edge; ptr=0 after release.
